// File: rtl/fft8_bitrev_reader.sv
// Single-frame 8-point reorder buffer: samples are written in natural order
// and read back in bit-reversed order, one frame at a time.
//
// state | meaning
// FILL  | accepting samples into mem[wr_cnt]; read side idle
// DRAIN | presenting mem[bitrev(rd_cnt)]; write side stalled
module fft8_bitrev_reader #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          sclr_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [2:0]    out_idx,
    output logic          out_last
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [2:0]      wr_cnt_q;
    logic [2:0]      wr_cnt_d;
    logic [2:0]      rd_cnt_q;
    logic [2:0]      rd_cnt_d;
    logic [2*DW-1:0] mem_q [8];

    logic            wr_hs;
    logic            rd_hs;
    logic [2:0]      rd_addr;
    logic [2*DW-1:0] rd_word;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state_q  <= FILL;
            wr_cnt_q <= 3'd0;
            rd_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Storage has no reset: a location is always rewritten before DRAIN exposes it.
    always_ff @(posedge clk) begin
        if (sclr_n && wr_hs) begin
            mem_q[wr_cnt_q] <= {in_re, in_im};
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        wr_hs     = 1'b0;
        rd_hs     = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                wr_hs    = in_valid;
                if (wr_hs) begin
                    wr_cnt_d = wr_cnt_q + 3'd1;
                    if (wr_cnt_q == 3'd7) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                rd_hs     = out_ready;
                if (rd_hs) begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                    if (rd_cnt_q == 3'd7) begin
                        state_d = FILL;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign rd_addr = bitrev3(rd_cnt_q);
    assign rd_word = mem_q[rd_addr];

    // Read data is gated so nothing from the buffer leaks out while filling.
    always_comb begin
        out_re   = '0;
        out_im   = '0;
        out_idx  = 3'd0;
        out_last = 1'b0;
        if (out_valid) begin
            out_re   = rd_word[2*DW-1:DW];
            out_im   = rd_word[DW-1:0];
            out_idx  = rd_cnt_q;
            out_last = (rd_cnt_q == 3'd7);
        end
    end

endmodule

// File: tb/tb_fft8_bitrev_reader.sv
// Scoreboard bench for fft8_bitrev_reader: a frame-level model predicts the
// reordered output stream, a negedge monitor compares every presented sample.
module tb_fft8_bitrev_reader;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          sclr_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [2:0]    out_idx;
    logic          out_last;

    fft8_bitrev_reader #(.DW(DW)) dut (
        .clk       (clk),
        .sclr_n    (sclr_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    idx;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] f_re [8];
    logic [DW-1:0] f_im [8];
    int            n_wr = 0;
    int            n_rd = 0;
    bit            m_fill = 1'b1;
    bit            started = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    bit            chk_period = 1'b0;
    int            prev_last = -1;

    // Frame-level model: collect 8 accepted samples, then emit them in
    // bit-reversed index order; 8 consumed outputs reopen the write side.
    always @(posedge clk) begin
        cyc++;
        if (!sclr_n) begin
            m_fill  = 1'b1;
            n_wr    = 0;
            n_rd    = 0;
            sb.delete();
            started = 1'b1;
        end else if (m_fill) begin
            if (in_valid) begin
                f_re[n_wr] = in_re;
                f_im[n_wr] = in_im;
                n_wr++;
                if (n_wr == 8) begin
                    for (int k = 0; k < 8; k++) begin
                        int src;
                        exp_t e;
                        src    = (k % 2) * 4 + ((k / 2) % 2) * 2 + (k / 4);
                        e.re   = f_re[src];
                        e.im   = f_im[src];
                        e.idx  = 3'(k);
                        e.last = (k == 7);
                        sb.push_back(e);
                    end
                    m_fill = 1'b0;
                    n_wr   = 0;
                end
            end
        end else if (out_ready) begin
            n_rd++;
            if (n_rd == 8) begin
                m_fill = 1'b1;
                n_rd   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if (in_ready !== m_fill || out_valid !== !m_fill) begin
                miscompares++;
                $display("FAIL handshake t=%0t: in_ready=%b out_valid=%b, required in_ready=%b out_valid=%b",
                         $time, in_ready, out_valid, m_fill, !m_fill);
            end
            vectors++;
            if (!m_fill) begin
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sample t=%0t: DUT presents data but no expected sample queued", $time);
                end else if (out_re !== sb[0].re || out_im !== sb[0].im ||
                             out_idx !== sb[0].idx || out_last !== sb[0].last) begin
                    miscompares++;
                    $display("FAIL sample t=%0t: got re=%0d im=%0d idx=%0d last=%b, required re=%0d im=%0d idx=%0d last=%b",
                             $time, out_re, out_im, out_idx, out_last,
                             sb[0].re, sb[0].im, sb[0].idx, sb[0].last);
                end
                if (out_ready && sb.size() > 0) begin
                    if (sb[0].last) begin
                        if (chk_period && prev_last >= 0) begin
                            vectors++;
                            if (cyc - prev_last != 16) begin
                                miscompares++;
                                $display("FAIL frame_period t=%0t: got %0d cycles, required 16",
                                         $time, cyc - prev_last);
                            end
                        end
                        prev_last = chk_period ? cyc : -1;
                    end
                    void'(sb.pop_front());
                end
            end else if (out_re !== '0 || out_im !== '0 || out_idx !== 3'd0 || out_last !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_zero t=%0t: got re=%0d im=%0d idx=%0d last=%b, required all 0",
                         $time, out_re, out_im, out_idx, out_last);
            end
        end
    end

    task automatic step(input bit iv, input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input bit ordy, input bit rn);
        in_valid  = iv;
        in_re     = re;
        in_im     = im;
        out_ready = ordy;
        sclr_n    = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input logic [2:0] k);
        int n;
        n = 0;
        while (!(out_valid === 1'b1 && out_idx === k) && n < 40) begin
            step(1'b0, '0, '0, 1'b1, 1'b1);
            n++;
        end
        vectors++;
        if (n >= 40) begin
            miscompares++;
            $display("FAIL wait_idx: out_idx=%0d never presented within 40 cycles", k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 16'd55, 16'd66, 1'b1, 1'b0);

        // Ramp frame, free-running drain
        for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 16'(100 + i), 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 1'b1);

        // Backpressure at k=2
        for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 16'($urandom), 1'b1, 1'b1);
        wait_idx(3'd2);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 1'b1);

        // Gapped writes, then more offers while draining is stalled
        for (int i = 0; i < 20; i++) step(i % 2 == 0, 16'($urandom), 16'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 1'b1);

        // in_valid held through DRAIN with changing data
        for (int i = 0; i < 26; i++) step(1'b1, 16'(200 + i), 16'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 1'b1);

        // Reset in the middle of a drain, then a fresh frame
        for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        wait_idx(3'd3);
        step(1'b1, 16'd999, 16'd999, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 16'(10 + i), 16'(300 + i), 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 1'b1);

        // Back-to-back frames
        chk_period = 1'b1;
        for (int i = 0; i < 70; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        chk_period = 1'b0;

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(1)), $urandom_range(59) != 0);
        for (int i = 0; i < 12; i++) step(1'b0, '0, '0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft8_bitrev_reader.md
FFT8_BITREV_READER -- requirements
Module: fft8_bitrev_reader

Interface
REQ-001 Parameter DW, default 16, is the width of each real and imaginary sample component.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 sclr_n  input  1  reset, synchronous and active-low; sampled on rising clk edge.
REQ-004 in_valid  input  1  write side: a sample is offered.
REQ-005 in_ready  output  1  write side: the block accepts a sample this cycle.
REQ-006 in_re, in_im  input  DW each  write side: sample components, two's complement.
REQ-007 out_valid  output  1  read side: a sample is presented.
REQ-008 out_ready  input  1  read side: the consumer takes the sample this cycle.
REQ-009 out_re, out_im  output  DW each  read side: sample components.
REQ-010 out_idx  output  3  read side: output sequence position k (0..7).
REQ-011 out_last  output  1  read side: high with the k=7 sample.

Function
REQ-012 The block SHALL buffer one 8-sample frame: natural-order writes, bit-reversed-order reads.
REQ-013 The state machine SHALL have two states, FILL and DRAIN.
REQ-014 In FILL: in_ready = 1, out_valid = 0; in DRAIN: in_ready = 0, out_valid = 1.
REQ-015 Write handshake = in_valid & in_ready; each handshake stores {in_re, in_im} at mem[wr_cnt] and increments 3-bit wr_cnt.
REQ-016 in_valid while in_ready = 0 SHALL be ignored; no storage, no counter change.
REQ-017 The handshake with wr_cnt = 7 SHALL wrap wr_cnt to 0 and move to DRAIN; out_valid goes high the next cycle (one-cycle latency from 8th write to first output).
REQ-018 In DRAIN: out_re/out_im = mem[bitrev(rd_cnt)], with bitrev mapping 0..7 to 0,4,2,6,1,5,3,7; out_idx = rd_cnt; out_last = (rd_cnt == 7).
REQ-019 Read handshake = out_valid & out_ready; each handshake increments 3-bit rd_cnt.
REQ-020 While out_ready = 0 in DRAIN, all outputs SHALL hold stable.
REQ-021 The handshake with rd_cnt = 7 SHALL wrap rd_cnt to 0 and return to FILL; in_ready goes high the next cycle.
REQ-022 The write and read sides SHALL never both be active in one cycle; with in_valid = out_ready = 1 permanently, throughput is one frame per 16 cycles.
REQ-023 out_re, out_im, out_idx, out_last SHALL be 0 whenever out_valid = 0.
REQ-024 Counters SHALL be 3 bits wide with natural modulo-8 wrap; no other wrap condition.

Reset
REQ-025 While sclr_n = 0 at a clk edge: state <= FILL, wr_cnt <= 0, rd_cnt <= 0.
REQ-026 After reset: in_ready = 1, out_valid = 0, out_re = out_im = 0, out_idx = 0, out_last = 0.
REQ-027 Reset SHALL take priority over any simultaneous handshake; a partial frame (in FILL or DRAIN) is discarded.
REQ-028 Buffer memory SHALL NOT need clearing on reset; its contents are never visible before being rewritten.

Verification
REQ-029 Reset then write re = 0..7, im = 100..107 with in_valid held -> out_valid rises one cycle after the 8th write; outputs re = 0,4,2,6,1,5,3,7, im = 100,104,102,106,101,105,103,107, out_idx = 0..7, out_last only on the 8th output.
REQ-030 Read backpressure: out_ready low 3 cycles at k = 2 -> out_re = 2, out_idx = 2 held stable; sequence then continues 6,1,5,3,7.
REQ-031 Write gaps: in_valid toggled 1,0,1,0 -> exactly 8 samples stored, DRAIN entered only after the 8th handshake.
REQ-032 in_valid = 1 throughout DRAIN with a changing in_re -> ignored; frame 2 starts at mem[0] when in_ready returns.
REQ-033 Assert sclr_n = 0 for one cycle at k = 3 of DRAIN -> next cycle in_ready = 1, out_valid = 0; new frame re = 10..17 drains as 10,14,12,16,11,15,13,17.
REQ-034 Back-to-back frames with in_valid = out_ready = 1 -> 16-cycle period, out_last every 16th cycle, no lost or duplicated samples.
